// File: rtl/core_types_pkg.sv
// Core-wide width definitions shared by the store/AMO/fence path.
package core_types_pkg;
  localparam int unsigned VPN_WIDTH              = 20;
  localparam int unsigned PO_WIDTH               = 12;
  localparam int unsigned LOG_STAMOFU_CQ_ENTRIES = 4;
endpackage

// File: rtl/stamofu_misaligned_splitter_pkg.sv
// Shared types for the misaligned store splitter: FSM state and access-size codes.
package stamofu_misaligned_splitter_pkg;
  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_SINGLE = 2'd1,
    ST_FIRST  = 2'd2,
    ST_SECOND = 2'd3
  } stamofu_split_state_t;

  // op[1:0] access size encodings
  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
endpackage

// File: rtl/stamofu_misaligned_splitter_if.sv
// Handshake bundle between the address pipeline REQ stage, the splitter and
// the dTLB/dcache request port.
//   REQ_*  : op offered by the address pipeline, REQ_ack returned by splitter
//   dreq_* : word-granular request issued by splitter, dreq_ready returned
// Modports: slave  = splitter view (consumes REQ, produces dreq)
//           master = surrounding pipeline view
interface stamofu_misaligned_splitter_if;
  import core_types_pkg::*;

  logic                              REQ_valid;
  logic                              REQ_is_store;
  logic                              REQ_is_amo;
  logic                              REQ_is_fence;
  logic [3:0]                        REQ_op;
  logic                              REQ_is_mq;
  logic                              REQ_misaligned;
  logic                              REQ_misaligned_exception;
  logic [VPN_WIDTH-1:0]              REQ_VPN;
  logic [PO_WIDTH-3:0]               REQ_PO_word;
  logic [3:0]                        REQ_byte_mask;
  logic [31:0]                       REQ_write_data;
  logic [LOG_STAMOFU_CQ_ENTRIES-1:0] REQ_cq_index;
  logic                              REQ_ack;

  logic                              dreq_valid;
  logic                              dreq_is_store;
  logic                              dreq_is_amo;
  logic                              dreq_is_fence;
  logic [3:0]                        dreq_op;
  logic                              dreq_is_mq;
  logic                              dreq_misaligned_exception;
  logic                              dreq_is_second;
  logic [VPN_WIDTH-1:0]              dreq_VPN;
  logic [PO_WIDTH-3:0]               dreq_PO_word;
  logic [3:0]                        dreq_byte_mask;
  logic [31:0]                       dreq_write_data;
  logic [LOG_STAMOFU_CQ_ENTRIES-1:0] dreq_cq_index;
  logic                              dreq_ready;

  modport slave (
    input  REQ_valid, REQ_is_store, REQ_is_amo, REQ_is_fence, REQ_op, REQ_is_mq,
           REQ_misaligned, REQ_misaligned_exception, REQ_VPN, REQ_PO_word,
           REQ_byte_mask, REQ_write_data, REQ_cq_index,
    output REQ_ack,
    output dreq_valid, dreq_is_store, dreq_is_amo, dreq_is_fence, dreq_op,
           dreq_is_mq, dreq_misaligned_exception, dreq_is_second, dreq_VPN,
           dreq_PO_word, dreq_byte_mask, dreq_write_data, dreq_cq_index,
    input  dreq_ready
  );

  modport master (
    output REQ_valid, REQ_is_store, REQ_is_amo, REQ_is_fence, REQ_op, REQ_is_mq,
           REQ_misaligned, REQ_misaligned_exception, REQ_VPN, REQ_PO_word,
           REQ_byte_mask, REQ_write_data, REQ_cq_index,
    input  REQ_ack,
    input  dreq_valid, dreq_is_store, dreq_is_amo, dreq_is_fence, dreq_op,
           dreq_is_mq, dreq_misaligned_exception, dreq_is_second, dreq_VPN,
           dreq_PO_word, dreq_byte_mask, dreq_write_data, dreq_cq_index,
    output dreq_ready
  );
endinterface

// File: rtl/stamofu_split_lane_shift.sv
// Combinational byte-lane alignment for a store.
//   byte_mask_i   : first-word byte mask
//   size_i        : access size (op[1:0])
//   write_data_i  : unshifted store data
//   first_mask_o / first_data_o   : first (or only) word mask and lane-aligned data
//   second_mask_o / second_data_o : spill-over word mask and data for a split
module stamofu_split_lane_shift
  import stamofu_misaligned_splitter_pkg::*;
(
  input  logic [3:0]  byte_mask_i,
  input  logic [1:0]  size_i,
  input  logic [31:0] write_data_i,
  output logic [3:0]  first_mask_o,
  output logic [31:0] first_data_o,
  output logic [3:0]  second_mask_o,
  output logic [31:0] second_data_o
);
  logic [1:0] k;
  logic [4:0] shl;
  logic [5:0] shr;

  // k = lowest enabled byte lane
  always_comb begin
    k = 2'd0;
    if      (byte_mask_i[0]) k = 2'd0;
    else if (byte_mask_i[1]) k = 2'd1;
    else if (byte_mask_i[2]) k = 2'd2;
    else if (byte_mask_i[3]) k = 2'd3;
  end

  assign shl = {k, 3'b000};
  // k=0 gives a shift of 32, which leaves no spill-over bytes
  assign shr = 6'd32 - {1'b0, shl};

  assign first_mask_o  = byte_mask_i;
  assign first_data_o  = write_data_i << shl;
  assign second_mask_o = (size_i == SIZE_H) ? 4'b0001 : ~byte_mask_i;
  assign second_data_o = write_data_i >> shr;
endmodule

// File: rtl/stamofu_misaligned_splitter.sv
// Splits misaligned stores from the store/AMO/fence address pipeline into two
// word-granular dTLB/dcache requests; everything else passes through as one.
//   CLK, RST    : clock, asynchronous active-high reset
//   bus         : REQ_* in / REQ_ack out, dreq_* out / dreq_ready in
//   split_count : saturating count of split stores issued
module stamofu_misaligned_splitter
  import core_types_pkg::*;
  import stamofu_misaligned_splitter_pkg::*;
#(
  parameter int unsigned SPLIT_COUNT_WIDTH = 16
) (
  input  logic                         CLK,
  input  logic                         RST,
  stamofu_misaligned_splitter_if.slave bus,
  output logic [SPLIT_COUNT_WIDTH-1:0] split_count
);
  localparam logic [VPN_WIDTH-1:0] VPN_ONE     = 1;
  localparam logic [PO_WIDTH-3:0]  PO_WORD_ONE = 1;

  stamofu_split_state_t state_q, state_d;
  logic [SPLIT_COUNT_WIDTH-1:0] split_count_q, split_count_d;

  logic req_ack, accept, advance, is_split;

  logic                              dreq_is_store_q;
  logic                              dreq_is_amo_q;
  logic                              dreq_is_fence_q;
  logic [3:0]                        dreq_op_q;
  logic                              dreq_is_mq_q;
  logic                              dreq_exc_q;
  logic                              dreq_is_second_q;
  logic [VPN_WIDTH-1:0]              dreq_VPN_q;
  logic [PO_WIDTH-3:0]               dreq_PO_word_q;
  logic [3:0]                        dreq_byte_mask_q;
  logic [31:0]                       dreq_write_data_q;
  logic [LOG_STAMOFU_CQ_ENTRIES-1:0] dreq_cq_index_q;

  // second-half mask/data captured at accept, presented after FIRST completes
  logic [3:0]  sec_mask_q;
  logic [31:0] sec_data_q;

  logic [3:0]  first_mask, second_mask;
  logic [31:0] first_data, second_data;

  stamofu_split_lane_shift u_lane_shift (
    .byte_mask_i   (bus.REQ_byte_mask),
    .size_i        (bus.REQ_op[1:0]),
    .write_data_i  (bus.REQ_write_data),
    .first_mask_o  (first_mask),
    .first_data_o  (first_data),
    .second_mask_o (second_mask),
    .second_data_o (second_data)
  );

  assign is_split = bus.REQ_misaligned & ~bus.REQ_misaligned_exception
                  & ~bus.REQ_is_fence & ~bus.REQ_is_amo;

  always_comb begin
    state_d = state_q;
    req_ack = 1'b0;
    unique case (state_q)
      ST_EMPTY:             req_ack = 1'b1;
      ST_SINGLE, ST_SECOND: req_ack = bus.dreq_ready;
      ST_FIRST:             req_ack = 1'b0;
      default:              req_ack = 1'b0;
    endcase
    accept  = bus.REQ_valid & req_ack;
    advance = (state_q == ST_FIRST) & bus.dreq_ready;
    if (accept) begin
      state_d = is_split ? ST_FIRST : ST_SINGLE;
    end else if ((state_q != ST_EMPTY) && bus.dreq_ready) begin
      state_d = (state_q == ST_FIRST) ? ST_SECOND : ST_EMPTY;
    end
    split_count_d = split_count_q;
    if (advance && !(&split_count_q)) begin
      split_count_d = split_count_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= ST_EMPTY;
      split_count_q <= '0;
    end else begin
      state_q       <= state_d;
      split_count_q <= split_count_d;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      dreq_is_store_q   <= 1'b0;
      dreq_is_amo_q     <= 1'b0;
      dreq_is_fence_q   <= 1'b0;
      dreq_op_q         <= '0;
      dreq_is_mq_q      <= 1'b0;
      dreq_exc_q        <= 1'b0;
      dreq_is_second_q  <= 1'b0;
      dreq_VPN_q        <= '0;
      dreq_PO_word_q    <= '0;
      dreq_byte_mask_q  <= '1;
      dreq_write_data_q <= '0;
      dreq_cq_index_q   <= '0;
      sec_mask_q        <= '0;
      sec_data_q        <= '0;
    end else if (accept) begin
      dreq_is_store_q   <= bus.REQ_is_store;
      dreq_is_amo_q     <= bus.REQ_is_amo;
      dreq_is_fence_q   <= bus.REQ_is_fence;
      dreq_op_q         <= bus.REQ_op;
      dreq_is_mq_q      <= bus.REQ_is_mq;
      dreq_exc_q        <= bus.REQ_misaligned_exception;
      dreq_is_second_q  <= 1'b0;
      dreq_VPN_q        <= bus.REQ_VPN;
      dreq_PO_word_q    <= bus.REQ_PO_word;
      dreq_byte_mask_q  <= first_mask;
      dreq_write_data_q <= first_data;
      dreq_cq_index_q   <= bus.REQ_cq_index;
      sec_mask_q        <= second_mask;
      sec_data_q        <= second_data;
    end else if (advance) begin
      // next word; a wrap of the word index crosses into the next page
      dreq_is_mq_q      <= 1'b1;
      dreq_is_second_q  <= 1'b1;
      dreq_PO_word_q    <= dreq_PO_word_q + PO_WORD_ONE;
      if (&dreq_PO_word_q) begin
        dreq_VPN_q <= dreq_VPN_q + VPN_ONE;
      end
      dreq_byte_mask_q  <= sec_mask_q;
      dreq_write_data_q <= sec_data_q;
    end
  end

  assign bus.REQ_ack                   = req_ack;
  assign bus.dreq_valid                = (state_q != ST_EMPTY);
  assign bus.dreq_is_store             = dreq_is_store_q;
  assign bus.dreq_is_amo               = dreq_is_amo_q;
  assign bus.dreq_is_fence             = dreq_is_fence_q;
  assign bus.dreq_op                   = dreq_op_q;
  assign bus.dreq_is_mq                = dreq_is_mq_q;
  assign bus.dreq_misaligned_exception = dreq_exc_q;
  assign bus.dreq_is_second            = dreq_is_second_q;
  assign bus.dreq_VPN                  = dreq_VPN_q;
  assign bus.dreq_PO_word              = dreq_PO_word_q;
  assign bus.dreq_byte_mask            = dreq_byte_mask_q;
  assign bus.dreq_write_data           = dreq_write_data_q;
  assign bus.dreq_cq_index             = dreq_cq_index_q;
  assign split_count                   = split_count_q;
endmodule

// File: tb/tb_stamofu_misaligned_splitter.sv
module tb_stamofu_misaligned_splitter;
  logic        CLK;
  logic        RST;
  logic [15:0] split_count;
  int          n_checks;
  int          n_errors;

  stamofu_misaligned_splitter_if bus ();

  stamofu_misaligned_splitter #(.SPLIT_COUNT_WIDTH(16)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .bus         (bus),
    .split_count (split_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_req(input logic st, input logic amo, input logic [3:0] op,
                         input logic mis, input logic exc,
                         input logic [19:0] vpn, input logic [9:0] po,
                         input logic [3:0] mask, input logic [31:0] data,
                         input logic [3:0] cq);
    bus.REQ_is_store             = st;
    bus.REQ_is_amo               = amo;
    bus.REQ_is_fence             = 1'b0;
    bus.REQ_op                   = op;
    bus.REQ_is_mq                = 1'b0;
    bus.REQ_misaligned           = mis;
    bus.REQ_misaligned_exception = exc;
    bus.REQ_VPN                  = vpn;
    bus.REQ_PO_word              = po;
    bus.REQ_byte_mask            = mask;
    bus.REQ_write_data           = data;
    bus.REQ_cq_index             = cq;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    RST = 1'b1;
    bus.REQ_valid  = 1'b0;
    bus.dreq_ready = 1'b1;
    set_req(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 20'h0, 10'h0, 4'h0, 32'h0, 4'h0);
    repeat (2) tick();

    // reset state
    check("rst_valid", 32'(bus.dreq_valid), 32'h0);
    check("rst_mask", 32'(bus.dreq_byte_mask), 32'hF);
    check("rst_count", 32'(split_count), 32'h0);
    check("rst_ack", 32'(bus.REQ_ack), 32'h1);
    RST = 1'b0;
    tick();
    check("idle_ack", 32'(bus.REQ_ack), 32'h1);
    check("idle_valid", 32'(bus.dreq_valid), 32'h0);

    // aligned SW, then a second aligned op back-to-back
    set_req(1'b1, 1'b0, 4'h2, 1'b0, 1'b0, 20'h12345, 10'h010, 4'hF, 32'hDEADBEEF, 4'h3);
    bus.REQ_valid = 1'b1;
    tick();
    check("al_valid", 32'(bus.dreq_valid), 32'h1);
    check("al_vpn", 32'(bus.dreq_VPN), 32'h12345);
    check("al_po", 32'(bus.dreq_PO_word), 32'h010);
    check("al_mask", 32'(bus.dreq_byte_mask), 32'hF);
    check("al_data", bus.dreq_write_data, 32'hDEADBEEF);
    check("al_second", 32'(bus.dreq_is_second), 32'h0);
    check("al_store", 32'(bus.dreq_is_store), 32'h1);
    check("al_op", 32'(bus.dreq_op), 32'h2);
    check("al_cq", 32'(bus.dreq_cq_index), 32'h3);
    set_req(1'b1, 1'b0, 4'h2, 1'b0, 1'b0, 20'h12345, 10'h011, 4'hF, 32'h01234567, 4'h4);
    #1;
    check("al2_ack", 32'(bus.REQ_ack), 32'h1);
    tick();
    bus.REQ_valid = 1'b0;
    check("al2_valid", 32'(bus.dreq_valid), 32'h1);
    check("al2_po", 32'(bus.dreq_PO_word), 32'h011);
    check("al2_data", bus.dreq_write_data, 32'h01234567);
    check("al2_cq", 32'(bus.dreq_cq_index), 32'h4);
    tick();
    check("al_done", 32'(bus.dreq_valid), 32'h0);

    // misaligned SW split
    set_req(1'b1, 1'b0, 4'h2, 1'b1, 1'b0, 20'h12345, 10'h020, 4'hC, 32'hAABBCCDD, 4'h5);
    bus.REQ_valid = 1'b1;
    tick();
    bus.REQ_valid = 1'b0;
    check("sw1_valid", 32'(bus.dreq_valid), 32'h1);
    check("sw1_mask", 32'(bus.dreq_byte_mask), 32'hC);
    check("sw1_data", bus.dreq_write_data, 32'hCCDD0000);
    check("sw1_po", 32'(bus.dreq_PO_word), 32'h020);
    check("sw1_second", 32'(bus.dreq_is_second), 32'h0);
    check("sw1_mq", 32'(bus.dreq_is_mq), 32'h0);
    check("sw1_ack", 32'(bus.REQ_ack), 32'h0);
    check("sw1_count", 32'(split_count), 32'h0);
    tick();
    check("sw2_valid", 32'(bus.dreq_valid), 32'h1);
    check("sw2_mask", 32'(bus.dreq_byte_mask), 32'h3);
    check("sw2_data", bus.dreq_write_data, 32'h0000AABB);
    check("sw2_po", 32'(bus.dreq_PO_word), 32'h021);
    check("sw2_vpn", 32'(bus.dreq_VPN), 32'h12345);
    check("sw2_mq", 32'(bus.dreq_is_mq), 32'h1);
    check("sw2_second", 32'(bus.dreq_is_second), 32'h1);
    check("sw2_cq", 32'(bus.dreq_cq_index), 32'h5);
    check("sw2_count", 32'(split_count), 32'h1);
    tick();
    check("sw_done", 32'(bus.dreq_valid), 32'h0);

    // misaligned SH at page end
    set_req(1'b1, 1'b0, 4'h1, 1'b1, 1'b0, 20'h00FFF, 10'h3FF, 4'h8, 32'h00001234, 4'h6);
    bus.REQ_valid = 1'b1;
    tick();
    bus.REQ_valid = 1'b0;
    check("sh1_mask", 32'(bus.dreq_byte_mask), 32'h8);
    check("sh1_data", bus.dreq_write_data, 32'h34000000);
    check("sh1_po", 32'(bus.dreq_PO_word), 32'h3FF);
    check("sh1_vpn", 32'(bus.dreq_VPN), 32'h00FFF);
    tick();
    check("sh2_mask", 32'(bus.dreq_byte_mask), 32'h1);
    check("sh2_data", bus.dreq_write_data, 32'h00000012);
    check("sh2_po", 32'(bus.dreq_PO_word), 32'h000);
    check("sh2_vpn", 32'(bus.dreq_VPN), 32'h01000);
    check("sh2_second", 32'(bus.dreq_is_second), 32'h1);
    check("sh2_count", 32'(split_count), 32'h2);
    tick();
    check("sh_done", 32'(bus.dreq_valid), 32'h0);

    // backpressure during FIRST
    set_req(1'b1, 1'b0, 4'h2, 1'b1, 1'b0, 20'h12345, 10'h040, 4'hC, 32'h11223344, 4'h7);
    bus.REQ_valid  = 1'b1;
    bus.dreq_ready = 1'b0;
    tick();
    bus.REQ_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("bp_valid", 32'(bus.dreq_valid), 32'h1);
      check("bp_mask", 32'(bus.dreq_byte_mask), 32'hC);
      check("bp_data", bus.dreq_write_data, 32'h33440000);
      check("bp_second", 32'(bus.dreq_is_second), 32'h0);
      check("bp_ack", 32'(bus.REQ_ack), 32'h0);
      if (i < 2) tick();
    end
    bus.dreq_ready = 1'b1;
    #1;
    check("bp_rel_ack", 32'(bus.REQ_ack), 32'h0);
    tick();
    check("bp2_mask", 32'(bus.dreq_byte_mask), 32'h3);
    check("bp2_data", bus.dreq_write_data, 32'h00001122);
    check("bp2_po", 32'(bus.dreq_PO_word), 32'h041);
    check("bp2_second", 32'(bus.dreq_is_second), 32'h1);
    check("bp2_count", 32'(split_count), 32'h3);
    tick();
    check("bp_done", 32'(bus.dreq_valid), 32'h0);

    // reset pulsed during FIRST drops the second half
    set_req(1'b1, 1'b0, 4'h2, 1'b1, 1'b0, 20'h12345, 10'h050, 4'hC, 32'h55667788, 4'h2);
    bus.REQ_valid = 1'b1;
    tick();
    bus.REQ_valid = 1'b0;
    check("rs_first_valid", 32'(bus.dreq_valid), 32'h1);
    RST = 1'b1;
    #2;
    check("rs_async_valid", 32'(bus.dreq_valid), 32'h0);
    check("rs_count", 32'(split_count), 32'h0);
    RST = 1'b0;
    tick();
    check("rs_next_valid", 32'(bus.dreq_valid), 32'h0);
    check("rs_next_second", 32'(bus.dreq_is_second), 32'h0);
    tick();
    check("rs_idle_valid", 32'(bus.dreq_valid), 32'h0);

    // misaligned exception passes through unsplit
    set_req(1'b1, 1'b0, 4'h2, 1'b1, 1'b1, 20'h12345, 10'h060, 4'hC, 32'hAABBCCDD, 4'h8);
    bus.REQ_valid = 1'b1;
    tick();
    bus.REQ_valid = 1'b0;
    check("ex_valid", 32'(bus.dreq_valid), 32'h1);
    check("ex_flag", 32'(bus.dreq_misaligned_exception), 32'h1);
    check("ex_second", 32'(bus.dreq_is_second), 32'h0);
    check("ex_mask", 32'(bus.dreq_byte_mask), 32'hC);
    check("ex_data", bus.dreq_write_data, 32'hCCDD0000);
    check("ex_ack", 32'(bus.REQ_ack), 32'h1);
    tick();
    check("ex_done", 32'(bus.dreq_valid), 32'h0);
    check("ex_count", 32'(split_count), 32'h0);

    // misaligned AMO passes through unsplit
    set_req(1'b0, 1'b1, 4'h2, 1'b1, 1'b0, 20'h12345, 10'h070, 4'hC, 32'hAABBCCDD, 4'h9);
    bus.REQ_valid = 1'b1;
    tick();
    bus.REQ_valid = 1'b0;
    check("amo_valid", 32'(bus.dreq_valid), 32'h1);
    check("amo_flag", 32'(bus.dreq_is_amo), 32'h1);
    check("amo_second", 32'(bus.dreq_is_second), 32'h0);
    check("amo_mask", 32'(bus.dreq_byte_mask), 32'hC);
    check("amo_data", bus.dreq_write_data, 32'hCCDD0000);
    tick();
    check("amo_done", 32'(bus.dreq_valid), 32'h0);
    check("amo_count", 32'(split_count), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
